ifu: RTL and testbench
======================

Name: ifu

Overview:
- Instruction fetch unit for the MIPS-lite datapath; sits directly upstream of the immediate extender.
- Holds the PC and runs a request/acknowledge handshake with instruction memory.
- Latches the fetched word into the instruction register (IR) and presents imm16 to the extender.
- Computes the next PC: sequential, branch (using the extender's sign-extended result), jump, or jr.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  memory has returned imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- stall  in  1  hazard/back-pressure; holds the current instruction.
- npc_sel  in  2  next-PC source: 00 pc+4, 01 branch, 10 jump, 11 jr.
- branch_taken  in  1  branch condition result; qualifies npc_sel=01.
- ext_out  in  32  sign-extended imm16 from the extender.
- jr_target  in  32  register value for jr.
- pc  out  32  address of the instruction in IR.
- pc_plus4  out  32  pc + 4, combinational.
- instr  out  32  IR contents.
- imm16  out  16  instr[15:0], combinational; feeds the extender.
- instr_valid  out  1  IR holds a valid instruction.
- fetch_err  out  1  sticky flag: misaligned jr target.

Behaviour:
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, state=START.
- State START:
  - Lasts one cycle after rst_n deasserts.
  - imem_req=0; any imem_ack is ignored, so stale acks from a fetch interrupted by reset are discarded.
  - Goes to FETCH.
- State FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On imem_ack: IR<=imem_rdata; next cycle instr_valid=1 and state=HOLD.
  - Ack is accepted regardless of stall.
  - Minimum fetch latency: 1 cycle from req to valid; ack may arrive in the first FETCH cycle.
- State HOLD:
  - imem_req=0, instr_valid=1.
  - If stall=1: remain in HOLD with pc and IR unchanged.
  - If stall=0 (advance): pc<=npc, state=FETCH, instr_valid drops the next cycle.
  - npc_sel, branch_taken, ext_out and jr_target are sampled only in the advance cycle.
- npc computation, 32-bit wrap-around with no overflow detection:
  - 00: pc_plus4.
  - 01 with branch_taken=1: pc_plus4 + (ext_out<<2).
  - 01 with branch_taken=0: pc_plus4.
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 11: jr_target.
- jr_target[1:0]!=0 in an advance cycle with npc_sel=11:
  - fetch_err<=1, state=ERR; pc is not updated.
  - ERR: imem_req=0, instr_valid=0, held until reset.
- imem_ack outside FETCH is ignored.
- Asynchronous reset at any point, including mid-FETCH, restores the reset values immediately.

Decomposition:
- Shared package holds:
  - npc_sel encodings: NPC_SEQ=2'b00, NPC_BR=2'b01, NPC_J=2'b10, NPC_JR=2'b11.
  - FSM state encodings: START, FETCH, HOLD, ERR.
  - Default RESET_PC constant.
- One natural sub-module: npc, a purely combinational next-PC mux/adder with inputs pc_plus4, npc_sel, branch_taken, ext_out, instr[25:0], jr_target and outputs npc and misalign.
- The FSM, PC and IR registers stay in ifu.

Test Plan:
- Reset release, memory acks on first request cycle with 32'h2408_0005:
  - cycle 1 has imem_req=0 (START);
  - cycle 2 has imem_req=1, imem_addr=32'h3000;
  - cycle 3 has instr=32'h2408_0005, instr_valid=1, imm16=16'h0005.
- Sequential advance with stall=0, npc_sel=00 from pc=32'h3000:
  - next request at 32'h3004;
  - 3-cycle ack delay gives instr_valid 1 cycle after the ack.
- Branch: pc=32'h3010, npc_sel=01, branch_taken=1, ext_out=32'hFFFF_FFFC -> next imem_addr=32'h3004; with branch_taken=0 -> 32'h3014.
- Jump: pc=32'h3000, instr=32'h0800_0C10 -> next imem_addr=32'h0000_3040.
- Stall and jr:
  - stall=1 for 5 cycles in HOLD: pc, instr unchanged, imem_req=0.
  - Then jr with jr_target=32'h3002: fetch_err=1, imem_req stays 0 until rst_n pulse.
- Reset mid-fetch: assert rst_n=0 while imem_req=1, then ack arrives in the START cycle -> ack ignored, instr_valid=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared encodings for the instruction fetch unit: next-PC select codes,
// fetch FSM states and the default reset PC.
package ifu_pkg;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [31:0] DefaultResetPc = 32'h0000_3000;

    typedef enum logic [1:0] {
        StStart = 2'b00,
        StFetch = 2'b01,
        StHold  = 2'b10,
        StErr   = 2'b11
    } ifu_state_e;

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC selection: sequential, branch, jump or register jump,
// plus a misalignment flag for the register-jump target.
module ifu_npc
    import ifu_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic [1:0]  npc_sel_i,
    input  logic        branch_taken_i,
    input  logic [31:0] ext_out_i,
    input  logic [25:0] instr_idx_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] npc_o,
    output logic        misalign_o
);

    always_comb begin
        npc_o = pc_plus4_i;
        unique case (npc_sel_i)
            NPC_SEQ: npc_o = pc_plus4_i;
            NPC_BR: begin
                if (branch_taken_i) begin
                    npc_o = pc_plus4_i + (ext_out_i << 2);
                end
            end
            NPC_J:   npc_o = {pc_plus4_i[31:28], instr_idx_i, 2'b00};
            NPC_JR:  npc_o = jr_target_i;
            default: npc_o = pc_plus4_i;
        endcase
    end

    assign misalign_o = |jr_target_i[1:0];

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC and IR registers plus the fetch handshake FSM
// (START -> FETCH -> HOLD, with a terminal ERR on a misaligned jr target).
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        branch_taken,
    input  logic [31:0] ext_out,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [15:0] imm16,
    output logic        instr_valid,
    output logic        fetch_err
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        err_q, err_d;
    logic [31:0] npc;
    logic        misalign;

    assign pc_plus4 = pc_q + 32'd4;

    ifu_npc u_npc (
        .pc_plus4_i     (pc_plus4),
        .npc_sel_i      (npc_sel),
        .branch_taken_i (branch_taken),
        .ext_out_i      (ext_out),
        .instr_idx_i    (ir_q[25:0]),
        .jr_target_i    (jr_target),
        .npc_o          (npc),
        .misalign_o     (misalign)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        err_d   = err_q;
        unique case (state_q)
            StStart: state_d = StFetch;
            StFetch: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!stall) begin
                    // A bad jr target freezes the PC so it still points at the jr.
                    if (npc_sel == NPC_JR && misalign) begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end else begin
                        pc_d    = npc;
                        state_d = StFetch;
                    end
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StStart;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StStart;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
        end
    end

    assign imem_req    = (state_q == StFetch);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == StHold);
    assign pc          = pc_q;
    assign instr       = ir_q;
    assign imm16       = ir_q[15:0];
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: reset/start-up, sequential, branch, jump, jr,
// stall, misaligned jr error and reset during an outstanding fetch.
module tb_ifu;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        branch_taken;
    logic [31:0] ext_out;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [15:0] imm16;
    logic        instr_valid;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    ifu #(.RESET_PC(32'h0000_3000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .npc_sel      (npc_sel),
        .branch_taken (branch_taken),
        .ext_out      (ext_out),
        .jr_target    (jr_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr        (instr),
        .imm16        (imm16),
        .instr_valid  (instr_valid),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle ack of the current fetch with the given word.
    task automatic do_fetch(input logic [31:0] w);
        imem_rdata = w;
        imem_ack   = 1'b1;
        step();
        imem_ack   = 1'b0;
    endtask

    // One advance cycle out of HOLD, then stall again.
    task automatic advance(input logic [1:0] sel, input logic bt,
                           input logic [31:0] ext, input logic [31:0] jr);
        npc_sel      = sel;
        branch_taken = bt;
        ext_out      = ext;
        jr_target    = jr;
        stall        = 1'b0;
        step();
        stall        = 1'b1;
        npc_sel      = 2'b00;
        branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (pc !== 32'h3000 || instr !== 32'h0 || instr_valid !== 1'b0 ||
            imem_req !== 1'b0 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values pc=%h instr=%h valid=%b req=%b err=%b exp 3000/0/0/0/0",
                     pc, instr, instr_valid, imem_req, fetch_err);
        end
        imem_rdata = 32'h2408_0005;
        imem_ack   = 1'b1;
        rst_n      = 1'b1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL start_no_req got %b exp 0", imem_req);
        end
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_req req=%b addr=%h valid=%b exp 1/00003000/0",
                     imem_req, imem_addr, instr_valid);
        end
        step();
        imem_ack = 1'b0;
        checks++;
        if (instr !== 32'h2408_0005 || instr_valid !== 1'b1 || imm16 !== 16'h0005 ||
            imem_req !== 1'b0 || pc_plus4 !== 32'h3004) begin
            errors++;
            $display("FAIL first_ir instr=%h valid=%b imm16=%h req=%b pc4=%h exp 24080005/1/0005/0/3004",
                     instr, instr_valid, imm16, imem_req, pc_plus4);
        end
    endtask

    task automatic test_seq();
        advance(2'b00, 1'b0, 32'h0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3004 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_req req=%b addr=%h valid=%b exp 1/00003004/0",
                     imem_req, imem_addr, instr_valid);
        end
        step();
        step();
        checks++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h2408_0005) begin
            errors++;
            $display("FAIL seq_wait req=%b valid=%b instr=%h exp 1/0/24080005",
                     imem_req, instr_valid, instr);
        end
        do_fetch(32'h0000_1111);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h0000_1111 || pc !== 32'h3004) begin
            errors++;
            $display("FAIL seq_ir valid=%b instr=%h pc=%h exp 1/00001111/00003004",
                     instr_valid, instr, pc);
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 3; i++) begin
            advance(2'b00, 1'b0, 32'h0, 32'h0);
            do_fetch(32'h0);
        end
        checks++;
        if (pc !== 32'h3010) begin
            errors++;
            $display("FAIL br_setup_pc got %h exp 00003010", pc);
        end
        advance(2'b01, 1'b1, 32'hFFFF_FFFC, 32'h0);
        checks++;
        if (imem_addr !== 32'h3004) begin
            errors++;
            $display("FAIL br_taken got %h exp 00003004", imem_addr);
        end
        do_fetch(32'h0);
        for (int i = 0; i < 3; i++) begin
            advance(2'b00, 1'b0, 32'h0, 32'h0);
            do_fetch(32'h0);
        end
        advance(2'b01, 1'b0, 32'hFFFF_FFFC, 32'h0);
        checks++;
        if (imem_addr !== 32'h3014) begin
            errors++;
            $display("FAIL br_not_taken got %h exp 00003014", imem_addr);
        end
        do_fetch(32'h0);
        advance(2'b01, 1'b1, 32'hFFFF_FFFA, 32'h0);
        checks++;
        if (imem_addr !== 32'h3000) begin
            errors++;
            $display("FAIL br_back got %h exp 00003000", imem_addr);
        end
        do_fetch(32'h0800_0C10);
    endtask

    task automatic test_jump();
        advance(2'b10, 1'b0, 32'h0, 32'h0);
        checks++;
        if (imem_addr !== 32'h0000_3040 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL jump addr=%h req=%b exp 00003040/1", imem_addr, imem_req);
        end
        do_fetch(32'h0000_2222);
    endtask

    task automatic test_jr();
        advance(2'b11, 1'b0, 32'h0, 32'h0000_3100);
        checks++;
        if (imem_addr !== 32'h3100 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL jr_aligned addr=%h err=%b exp 00003100/0", imem_addr, fetch_err);
        end
        do_fetch(32'h1234_5678);
    endtask

    task automatic test_stall_err();
        imem_rdata = 32'hAAAA_5555;
        for (int i = 0; i < 5; i++) begin
            imem_ack = i[0];
            step();
            checks++;
            if (pc !== 32'h3100 || instr !== 32'h1234_5678 || imem_req !== 1'b0 ||
                instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d pc=%h instr=%h req=%b valid=%b exp 3100/12345678/0/1",
                         i, pc, instr, imem_req, instr_valid);
            end
        end
        imem_ack = 1'b0;
        advance(2'b11, 1'b0, 32'h0, 32'h0000_3002);
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
            pc !== 32'h3100) begin
            errors++;
            $display("FAIL jr_misalign err=%b req=%b valid=%b pc=%h exp 1/0/0/00003100",
                     fetch_err, imem_req, instr_valid, pc);
        end
        stall = 1'b0;
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL err_sticky cyc=%0d err=%b req=%b valid=%b exp 1/0/0",
                         i, fetch_err, imem_req, instr_valid);
            end
        end
        imem_ack = 1'b0;
        stall = 1'b1;
    endtask

    task automatic test_reset_mid_fetch();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_refetch req=%b err=%b exp 1/0", imem_req, fetch_err);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h3000 || instr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_async req=%b pc=%h instr=%h valid=%b exp 0/3000/0/0",
                     imem_req, pc, instr, instr_valid);
        end
        imem_rdata = 32'hDEAD_BEEF;
        imem_ack   = 1'b1;
        step();
        rst_n = 1'b1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_start_req got %b exp 0", imem_req);
        end
        step();
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || instr_valid !== 1'b0 ||
            instr !== 32'h0) begin
            errors++;
            $display("FAIL stale_ack req=%b addr=%h valid=%b instr=%h exp 1/00003000/0/0",
                     imem_req, imem_addr, instr_valid, instr);
        end
        step();
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL stale_ack_wait valid=%b instr=%h req=%b exp 0/0/1",
                     instr_valid, instr, imem_req);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        stall        = 1'b1;
        npc_sel      = 2'b00;
        branch_taken = 1'b0;
        ext_out      = 32'h0;
        jr_target    = 32'h0;
        test_reset();
        test_seq();
        test_branch();
        test_jump();
        test_jr();
        test_stall_err();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
